// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write-port scheduler and its frame generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CPU   = 2'd1,
        REQ   = 2'd2,
        FRAME = 2'd3
    } state_e;

    // Upper half-word tags that mark an LCD word as a command or as pixel data
    localparam logic [15:0] LCD_CMD = 16'h8001;
    localparam logic [15:0] LCD_DAT = 16'h8002;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Frame pacing: free-running tick counter gated by game_en, with a pending flag
// for the scheduler and a sticky overrun flag.
module lcd_tick_gen
    import lcd_pkg::*;
#(
    parameter int TICK_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic game_en,
    input  logic tick_clr,
    output logic tick_pending,
    output logic frame_drop
);

    localparam int            TW        = cnt_w(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] r_tick_cnt;
    logic          r_pending;
    logic          r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_pending  <= 1'b0;
            r_drop     <= 1'b0;
        end else if (!game_en) begin
            r_tick_cnt <= '0;
            r_pending  <= 1'b0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
            r_pending  <= 1'b1;
            // A pending tick being consumed this cycle is not an overrun
            if (r_pending && !tick_clr)
                r_drop <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (tick_clr)
                r_pending <= 1'b0;
        end
    end

    assign tick_pending = r_pending;
    assign frame_drop   = r_drop;

endmodule

// File: rtl/lcd_frame_sched.sv
// Arbitrates the single LCD write port between CPU words and whole generator frames;
// a frame is never interleaved with CPU traffic.
module lcd_frame_sched
    import lcd_pkg::*;
#(
    parameter int TICK_CYCLES = 2_000_000,
    parameter int CPU_BURST   = 4,
    parameter int SRC_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_en,
    input  logic        cpu_wr_valid,
    input  logic [31:0] cpu_wr_data,
    output logic        cpu_wr_ready,
    output logic        frame_update,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    input  logic        src_last,
    output logic        src_ready,
    output logic        lcd_valid,
    output logic [31:0] lcd_data,
    input  logic        lcd_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        frame_drop,
    output logic        src_err
);

    localparam int            BW         = cnt_w(CPU_BURST);
    localparam int            WW         = cnt_w(SRC_TIMEOUT);
    localparam logic [BW-1:0] BURST_LAST = BW'(CPU_BURST - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SRC_TIMEOUT - 1);

    state_e        r_state;
    logic [BW-1:0] r_burst_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic [15:0]   r_frame_cnt;
    logic          r_src_err;

    logic w_tick_pending;
    logic w_tick_clr;
    logic w_cpu_xfer;
    logic w_src_xfer;

    lcd_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk          (clk),
        .reset        (reset),
        .game_en      (game_en),
        .tick_clr     (w_tick_clr),
        .tick_pending (w_tick_pending),
        .frame_drop   (frame_drop)
    );

    // The pending tick is consumed in the same cycle the IDLE->REQ decision is made
    assign w_tick_clr = (r_state == IDLE) && w_tick_pending && game_en;
    assign w_cpu_xfer = (r_state == CPU)   && cpu_wr_valid && lcd_ready;
    assign w_src_xfer = (r_state == FRAME) && src_valid    && lcd_ready;

    always_comb begin
        lcd_valid = 1'b0;
        lcd_data  = '0;
        case (r_state)
            CPU: begin
                lcd_valid = cpu_wr_valid;
                lcd_data  = cpu_wr_data;
            end
            FRAME: begin
                lcd_valid = src_valid;
                lcd_data  = src_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_wait_cnt  <= '0;
            r_frame_cnt <= '0;
            r_src_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick_pending && game_en) begin
                        r_state <= REQ;
                    end else if (cpu_wr_valid) begin
                        r_state     <= CPU;
                        r_burst_cnt <= '0;
                    end
                end
                CPU: begin
                    if (!cpu_wr_valid) begin
                        r_state <= IDLE;
                    end else if (w_cpu_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (r_burst_cnt == BURST_LAST || w_tick_pending)
                            r_state <= IDLE;
                    end
                end
                REQ: begin
                    r_state    <= FRAME;
                    r_wait_cnt <= '0;
                end
                FRAME: begin
                    if (w_src_xfer) begin
                        r_wait_cnt <= '0;
                        if (src_last) begin
                            r_state     <= IDLE;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end else if (!src_valid) begin
                        // A silent generator must not hold the port forever
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_state   <= IDLE;
                            r_src_err <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_wr_ready = (r_state == CPU)   && lcd_ready;
    assign src_ready    = (r_state == FRAME) && lcd_ready;
    assign frame_update = (r_state == REQ);
    assign busy         = (r_state != IDLE);
    assign frame_cnt    = r_frame_cnt;
    assign src_err      = r_src_err;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Scoreboard bench for lcd_frame_sched: CPU and generator words are queued when presented
// and popped by a monitor on every LCD transfer.
module tb_lcd_frame_sched;
    import lcd_pkg::*;

    localparam int TICK  = 8;
    localparam int BURST = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_en;
    logic        cpu_wr_valid;
    logic [31:0] cpu_wr_data;
    logic        cpu_wr_ready;
    logic        frame_update;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_last;
    logic        src_ready;
    logic        lcd_valid;
    logic [31:0] lcd_data;
    logic        lcd_ready;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        frame_drop;
    logic        src_err;

    always #5 clk = ~clk;

    lcd_frame_sched #(
        .TICK_CYCLES (TICK),
        .CPU_BURST   (BURST),
        .SRC_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .game_en      (game_en),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .frame_update (frame_update),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .lcd_valid    (lcd_valid),
        .lcd_data     (lcd_data),
        .lcd_ready    (lcd_ready),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .frame_drop   (frame_drop),
        .src_err      (src_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] frm_q[$];
    int          cpu_cyc_q[$];
    int          frm_xfers = 0;
    int          frm_last_cyc = -1;
    int          gen_len = 0;
    int          gen_stall_at = -1;
    int          gen_stall_n = 0;
    logic [7:0]  frame_tag = 8'h00;
    logic [31:0] m_exp;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] frm_word(input int idx);
        logic [7:0] i8;
        i8 = idx[7:0];
        if (idx == 0) return {LCD_CMD, 16'h002C};
        return {LCD_DAT, frame_tag, i8};
    endfunction

    // Monitor: every LCD transfer must belong to exactly one granted requester, in order
    always @(negedge clk) begin
        if (!reset && lcd_valid && lcd_ready) begin
            checks++;
            if (cpu_wr_ready && src_ready) begin
                errors++;
                $display("FAIL xfer_grant: both readies high, data %h", lcd_data);
            end else if (cpu_wr_ready) begin
                if (cpu_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_xfer: got %h, expected no CPU word", lcd_data);
                end else begin
                    m_exp = cpu_q.pop_front();
                    if (lcd_data !== m_exp) begin
                        errors++;
                        $display("FAIL cpu_xfer: got %h, expected %h", lcd_data, m_exp);
                    end
                    cpu_cyc_q.push_back(cyc);
                end
            end else if (src_ready) begin
                if (frm_q.size() == 0) begin
                    errors++;
                    $display("FAIL frm_xfer: got %h, expected no frame word", lcd_data);
                end else begin
                    m_exp = frm_q.pop_front();
                    if (lcd_data !== m_exp) begin
                        errors++;
                        $display("FAIL frm_xfer: got %h, expected %h", lcd_data, m_exp);
                    end
                    frm_xfers++;
                    if (src_last) frm_last_cyc = cyc;
                end
            end else begin
                errors++;
                $display("FAIL xfer_grant: transfer %h with no ready, expected a grant", lcd_data);
            end
        end
    end

    // Generator model: restarts on frame_update, advances only on accepted words
    initial begin : gen
        logic s_fu, s_x, s_rst, act;
        int   idx, pushed, stall_left;
        src_valid = 1'b0; src_data = '0; src_last = 1'b0;
        act = 1'b0; idx = 0; pushed = -1; stall_left = 0;
        forever begin
            @(negedge clk);
            s_fu  = frame_update;
            s_x   = src_valid && src_ready;
            s_rst = reset;
            @(posedge clk); #1;
            if (s_rst) act = 1'b0;
            else if (s_fu) begin
                act = 1'b1; idx = 0; pushed = -1; stall_left = gen_stall_n;
            end else if (act && s_x) idx++;
            if (act && idx >= gen_len) act = 1'b0;
            if (act && idx == gen_stall_at && stall_left > 0) begin
                src_valid = 1'b0; src_last = 1'b0; stall_left--;
            end else if (act) begin
                src_valid = 1'b1;
                src_data  = frm_word(idx);
                src_last  = (idx == gen_len - 1);
                if (idx != pushed) begin
                    frm_q.push_back(src_data);
                    pushed = idx;
                end
            end else begin
                src_valid = 1'b0; src_last = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; game_en = 1'b0; cpu_wr_valid = 1'b0; lcd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cpu_q.delete(); frm_q.delete(); cpu_cyc_q.delete();
        frm_xfers = 0; frm_last_cyc = -1;
        reset = 1'b0;
    endtask

    task automatic wait_fu(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_update) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: frame_update never seen, expected a pulse within 100 cycles", nm);
        end
    endtask

    task automatic cpu_send(input int n, input logic [31:0] base);
        bit acc;
        for (int k = 0; k < n; k++) begin
            acc = 1'b0;
            cpu_wr_valid = 1'b1;
            cpu_wr_data  = base + 32'(k);
            cpu_q.push_back(base + 32'(k));
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = cpu_wr_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL cpu_send: word %0d not accepted, expected accept within 100 cycles", k);
                break;
            end
        end
        cpu_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; game_en = 1'b1; cpu_wr_valid = 1'b1; cpu_wr_data = 32'hDEAD_BEEF; lcd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (frame_cnt !== 16'h0)   begin errors++; $display("FAIL rst_frame_cnt: got %h, expected 0", frame_cnt); end
        checks++; if (frame_drop !== 1'b0)   begin errors++; $display("FAIL rst_frame_drop: got %b, expected 0", frame_drop); end
        checks++; if (src_err !== 1'b0)      begin errors++; $display("FAIL rst_src_err: got %b, expected 0", src_err); end
        checks++; if (frame_update !== 1'b0) begin errors++; $display("FAIL rst_frame_update: got %b, expected 0", frame_update); end
        checks++; if (lcd_valid !== 1'b0)    begin errors++; $display("FAIL rst_lcd_valid: got %b, expected 0", lcd_valid); end
        checks++; if (lcd_data !== 32'h0)    begin errors++; $display("FAIL rst_lcd_data: got %h, expected 0", lcd_data); end
        checks++; if (cpu_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready: got %b, expected 0", cpu_wr_ready); end
        checks++; if (src_ready !== 1'b0)    begin errors++; $display("FAIL rst_src_ready: got %b, expected 0", src_ready); end
        @(posedge clk); #1;
        cpu_wr_valid = 1'b0; game_en = 1'b0;
    endtask

    task automatic test_frame();
        bit ok;
        int fu_cyc, pulses, busy_low_cyc;
        do_reset();
        gen_len = 5; gen_stall_at = -1; gen_stall_n = 0; frame_tag = 8'h01; game_en = 1'b1;
        wait_fu("t1_fu", ok);
        fu_cyc = cyc; pulses = 1; busy_low_cyc = -1;
        checks++;
        if (fu_cyc !== 9) begin errors++; $display("FAIL t1_fu_cycle: got %0d, expected 9", fu_cyc); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_update) pulses++;
            if (!busy) begin busy_low_cyc = cyc; break; end
        end
        checks++;
        if (busy_low_cyc < 0 || busy_low_cyc !== frm_last_cyc + 1) begin
            errors++; $display("FAIL t1_busy_drop: got cycle %0d, expected %0d", busy_low_cyc, frm_last_cyc + 1);
        end
        checks++; if (frm_xfers !== 5)     begin errors++; $display("FAIL t1_xfers: got %0d, expected 5", frm_xfers); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t1_frame_cnt: got %0d, expected 1", frame_cnt); end
        checks++; if (pulses !== 1)        begin errors++; $display("FAIL t1_pulses: got %0d, expected 1", pulses); end
        checks++; if (frm_q.size() !== 0)  begin errors++; $display("FAIL t1_leftover: got %0d, expected 0", frm_q.size()); end
        @(posedge clk); #1;
        game_en = 1'b0;
    endtask

    task automatic test_cpu_burst();
        int exp_d[5];
        exp_d = '{1, 1, 1, 2, 1};
        do_reset();
        cpu_send(6, 32'hC0DE_0000);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cpu_cyc_q.size() !== 6) begin
            errors++; $display("FAIL t2_count: got %0d, expected 6", cpu_cyc_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (cpu_cyc_q[i+1] - cpu_cyc_q[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL t2_gap%0d: got %0d, expected %0d", i, cpu_cyc_q[i+1] - cpu_cyc_q[i], exp_d[i]);
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle: got busy %b, expected 0", busy); end
    endtask

    task automatic test_tick_vs_cpu();
        bit fu_seen, acc;
        do_reset();
        gen_len = 4; gen_stall_at = -1; gen_stall_n = 0; frame_tag = 8'h03; game_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        cpu_wr_valid = 1'b1; cpu_wr_data = 32'hA5A5_0001; cpu_q.push_back(32'hA5A5_0001);
        fu_seen = 1'b0; acc = 1'b0;
        for (int t = 0; t < 80 && !acc; t++) begin
            @(negedge clk);
            if (frame_update) fu_seen = 1'b1;
            checks++;
            if (cpu_wr_ready && frm_last_cyc < 0) begin
                errors++; $display("FAIL t3_cpu_blocked: cpu_wr_ready 1 at cycle %0d, expected 0 before src_last", cyc);
            end
            acc = cpu_wr_ready;
            @(posedge clk); #1;
            if (fu_seen) game_en = 1'b0;
            if (acc) cpu_wr_valid = 1'b0;
        end
        cpu_wr_valid = 1'b0;
        checks++; if (!fu_seen) begin errors++; $display("FAIL t3_fu: got no pulse, expected frame first"); end
        checks++; if (!acc)     begin errors++; $display("FAIL t3_cpu_accept: got none, expected CPU word after frame"); end
        checks++;
        if (cpu_cyc_q.size() !== 1 || frm_last_cyc < 0 || cpu_cyc_q[0] <= frm_last_cyc) begin
            errors++; $display("FAIL t3_order: got %0d cpu xfers, frame last at %0d, expected one CPU xfer after it", cpu_cyc_q.size(), frm_last_cyc);
        end
        checks++; if (frm_q.size() !== 0) begin errors++; $display("FAIL t3_leftover: got %0d, expected 0", frm_q.size()); end
    endtask

    task automatic test_ready_toggle();
        bit ok;
        do_reset();
        gen_len = 6; gen_stall_at = -1; gen_stall_n = 0; frame_tag = 8'h04; game_en = 1'b1;
        wait_fu("t4_fu", ok);
        @(posedge clk); #1;
        game_en = 1'b0; lcd_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy) break;
            checks++;
            if (src_ready !== lcd_ready) begin
                errors++; $display("FAIL t4_src_ready: got %b, expected %b", src_ready, lcd_ready);
            end
            @(posedge clk); #1;
            lcd_ready = ~lcd_ready;
        end
        @(posedge clk); #1;
        lcd_ready = 1'b1;
        checks++; if (frm_xfers !== 6)     begin errors++; $display("FAIL t4_xfers: got %0d, expected 6", frm_xfers); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t4_frame_cnt: got %0d, expected 1", frame_cnt); end
        checks++; if (frm_q.size() !== 0)  begin errors++; $display("FAIL t4_leftover: got %0d, expected 0", frm_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok, found;
        do_reset();
        gen_len = 10; gen_stall_at = 3; gen_stall_n = 1000; frame_tag = 8'h05; game_en = 1'b1;
        wait_fu("t5_fu", ok);
        @(posedge clk); #1;
        game_en = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!src_valid) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL t5_stall: got no stall, expected src_valid low"); end
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || src_err !== 1'b0) begin
            errors++; $display("FAIL t5_early: got busy %b src_err %b, expected 1 0", busy, src_err);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL t5_idle: got busy %b, expected 0", busy); end
        checks++; if (src_err !== 1'b1)    begin errors++; $display("FAIL t5_src_err: got %b, expected 1", src_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL t5_frame_cnt: got %0d, expected 0", frame_cnt); end
        checks++; if (frm_xfers !== 3)     begin errors++; $display("FAIL t5_xfers: got %0d, expected 3", frm_xfers); end
        gen_stall_at = -1; gen_stall_n = 0;
    endtask

    task automatic test_drop_and_reset();
        bit ok, seen;
        do_reset();
        gen_len = 20; gen_stall_at = -1; gen_stall_n = 0; frame_tag = 8'h06; game_en = 1'b1;
        wait_fu("t6_fu", ok);
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL t6_no_drop: got %b, expected 0", frame_drop); end
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (frame_drop) begin seen = 1'b1; break; end
        end
        checks++; if (!seen)         begin errors++; $display("FAIL t6_drop: got 0, expected frame_drop 1"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_in_frame: got busy %b, expected 1", busy); end
        do_reset();
        @(negedge clk);
        checks++; if (frame_drop !== 1'b0)  begin errors++; $display("FAIL t6_rst_drop: got %b, expected 0", frame_drop); end
        checks++; if (src_err !== 1'b0)     begin errors++; $display("FAIL t6_rst_err: got %b, expected 0", src_err); end
        checks++; if (frame_cnt !== 16'd0)  begin errors++; $display("FAIL t6_rst_cnt: got %0d, expected 0", frame_cnt); end
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (lcd_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL t6_abandon: got lcd_valid %b busy %b, expected 0 0", lcd_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_cpu_burst();
        test_tick_vs_cpu();
        test_ready_toggle();
        test_timeout();
        test_drop_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
